// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for two result producers feeding one register-file write
// port, plus a pending-write scoreboard used by issue for hazard detection.
//
// Handshake: a request is accepted in any cycle where reqN_valid and
// reqN_ready are both high at the rising clock edge. Ready is a combinational
// grant that depends on the valids. At most one ready is high per cycle, and
// neither is ever high while rst_n is low.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy_vec
);

    // Requester that won the most recent accept. It resets to 1 so that
    // requester 0 wins the first contention.
    logic            last_grant;
    logic            acc0;
    logic            acc1;
    logic            acc_any;
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_data;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that did not win last time wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n) begin
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign acc_any  = acc0 || acc1;
    assign acc_rd   = acc1 ? req1_rd : req0_rd;
    assign acc_data = acc1 ? req1_data : req0_data;

    // Remember the winner of every accept, including writes to x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (acc_any) begin
            last_grant <= acc1;
        end
    end

    // Registered write port. An accept to x0 is consumed silently, and the
    // address and data hold whenever no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (acc_any && (acc_rd != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= acc_rd;
            rf_wdata <= acc_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard next state: the clear is applied first so that a same-edge
    // alloc to the register being written leaves its bit set. Bit 0 is never set.
    always_comb begin
        busy_d = busy_q;
        if (rf_we) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != 5'd0)) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            req0_valid;
    logic            req0_ready;
    logic [4:0]      req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req1_valid;
    logic            req1_ready;
    logic [4:0]      req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            alloc_valid;
    logic [4:0]      alloc_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     busy_vec;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd(req1_rd), .req1_data(req1_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: pending writes as {rd, data}, the last committed write,
    // the pending-register set, and the last winner.
    logic [36:0] exp_q[$];
    logic [36:0] m_hold;
    logic [31:0] m_busy;
    int          m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_hold = '0;
        m_busy = '0;
        m_last = 1;
    endtask

    // Compare all outputs against the model for the current inputs, advance
    // the model by one clock, then wait for the next falling edge.
    task automatic step();
        int          g;
        logic [4:0]  rd;
        logic [36:0] ent;
        #1;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        else                          g = -1;
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("busy_vec", busy_vec, m_busy);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        chk("rf_we", rf_we, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            m_hold = ent;
            m_busy[ent[36:32]] = 1'b0;
        end
        chk("rf_waddr", rf_waddr, m_hold[36:32]);
        chk("rf_wdata", rf_wdata, m_hold[31:0]);
        if (alloc_valid) m_busy[alloc_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (g >= 0) begin
            m_last = g;
            rd = (g == 1) ? req1_rd : req0_rd;
            if (rd != 5'd0) exp_q.push_back({rd, (g == 1) ? req1_data : req0_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; alloc_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
        alloc_rd = '0; rs1 = '0; rs2 = '0;
        model_reset();

        // Reset state, with a requester knocking.
        req0_valid = 1'b1;
        #3;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // First contention: requester 0 wins, then requester 1.
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h22;
        #1;
        chk("c0_req0_ready", req0_ready, 1'b1);
        chk("c0_req1_ready", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("c1_rf_we", rf_we, 1'b1);
        chk("c1_rf_waddr", rf_waddr, 5'd5);
        chk("c1_rf_wdata", rf_wdata, 32'h11);
        chk("c1_req1_ready", req1_ready, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("c2_rf_waddr", rf_waddr, 5'd6);
        chk("c2_rf_wdata", rf_wdata, 32'h22);
        step();

        // Sustained contention alternates 0,1,0,1,0,1.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_data = 32'h100 + i; req1_data = 32'h200 + i;
            #1;
            chk("alt_req0_ready", req0_ready, (i % 2) == 0);
            if (i > 0) chk("alt_rf_we", rf_we, 1'b1);
            step();
        end
        idle_inputs();
        step();

        // Alloc rd 7, written by requester 1 three cycles later.
        rs1 = 5'd7;
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        step();
        alloc_valid = 1'b0;
        #1;
        chk("x7_busy_after_alloc", rs1_busy, 1'b1);
        step();
        step();
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'hDEAD;
        #1;
        chk("x7_busy_at_accept", rs1_busy, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("x7_rf_we", rf_we, 1'b1);
        chk("x7_busy_during_write", rs1_busy, 1'b1);
        step();
        #1;
        chk("x7_busy_cleared", rs1_busy, 1'b0);
        chk("x7_busy_vec", busy_vec, 32'h0);
        step();

        // A write to x0 is consumed without a write; requester 1 wins next.
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF;
        step();
        req0_valid = 1'b0;
        #1;
        chk("x0_rf_we", rf_we, 1'b0);
        chk("x0_rf_waddr_hold", rf_waddr, 5'd7);
        chk("x0_rf_wdata_hold", rf_wdata, 32'hDEAD);
        req0_valid = 1'b1; req0_rd = 5'd1; req1_valid = 1'b1; req1_rd = 5'd2;
        #1;
        chk("x0_next_grant_req1", req1_ready, 1'b1);
        step();
        idle_inputs();
        step();
        step();

        // Same-edge clear and set of register 9 keeps it set; alloc x0 is ignored.
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        step();
        alloc_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
        step();
        req0_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        #1;
        chk("b9_rf_we", rf_we, 1'b1);
        chk("b9_rf_waddr", rf_waddr, 5'd9);
        step();
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        #1;
        chk("b9_still_set", busy_vec[9], 1'b1);
        step();
        alloc_valid = 1'b0;
        #1;
        chk("b0_never_set", busy_vec[0], 1'b0);
        req0_valid = 1'b1; req0_rd = 5'd9;
        step();
        req0_valid = 1'b0;
        step();
        step();

        // Asynchronous reset while a write is outstanding.
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        step();
        alloc_rd = 5'd10;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h3333;
        step();
        idle_inputs();
        req0_valid = 1'b1;
        #1;
        chk("ar_pre_busy_vec", busy_vec, 32'h0000_0480);
        chk("ar_pre_rf_we", rf_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rf_we", rf_we, 1'b0);
        chk("ar_busy_vec", busy_vec, 32'h0);
        chk("ar_rf_waddr", rf_waddr, 5'd0);
        chk("ar_rf_wdata", rf_wdata, 32'h0);
        chk("ar_req0_ready", req0_ready, 1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            req0_valid  = ($urandom_range(0, 99) < 60);
            req1_valid  = ($urandom_range(0, 99) < 50);
            req0_rd     = 5'($urandom_range(0, 15));
            req1_rd     = 5'($urandom_range(0, 15));
            req0_data   = $urandom;
            req1_data   = $urandom;
            alloc_valid = ($urandom_range(0, 99) < 40);
            alloc_rd    = 5'($urandom_range(0, 15));
            rs1         = 5'($urandom_range(0, 15));
            rs2         = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
